// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbitrated mux.
// No logic of its own; the rotating search helper is pure combinational.
// Backpressure is not handled here; see mux4_rr_arbiter.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Rotating priority search starting at ptr; returns ptr itself when nothing
    // is requesting (callers only use the result when some request is set).
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req_vec,
        input logic [SEL_W-1:0]   ptr_val
    );
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] result;
        logic             found;
        result = ptr_val;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr_val + SEL_W'(i);
            if (!found && req_vec[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux4to1_bus.sv
// 4:1 data bus multiplexer selected by an encoded index.
// Purely combinational, zero latency.
// No flow control; the arbiter qualifies the output with its valid.
import mux4_arb_pkg::*;

module mux4to1_bus #(
    parameter int DW = 8
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [DW-1:0]    in0,
    input  logic [DW-1:0]    in1,
    input  logic [DW-1:0]    in2,
    input  logic [DW-1:0]    in3,
    output logic [DW-1:0]    out
);

    // Route the selected requester bus to the output.
    always_comb begin
        out = in0;
        case (sel)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters a burst onto a shared bus.
// Grant registered one cycle after request; data/valid flow combinationally while BUSY.
// out_ready low stalls the burst indefinitely; one idle cycle always separates grants.
import mux4_arb_pkg::*;

module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4    // accepted beats per grant, 1..15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic [DW-1:0]      in0,
    input  logic [DW-1:0]      in1,
    input  logic [DW-1:0]      in2,
    input  logic [DW-1:0]      in3,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [3:0]       hold_cnt;
    logic [3:0]       hold_next;
    logic [SEL_W-1:0] winner;
    logic             xfer;
    logic             burst_end;

    // Valid follows the granted request only; other requesters are invisible while BUSY.
    assign out_valid = busy & req[sel];
    assign xfer      = out_valid & out_ready;
    assign hold_next = hold_cnt + 4'd1;
    assign winner    = rr_pick(req, ptr);

    // A burst ends on its final beat, on reaching the hold limit, or when the
    // owner withdraws its request. last and the hold limit coinciding is one event.
    assign burst_end = ~req[sel] | (xfer & (last[sel] | (hold_next == HOLD_LIMIT)));

    mux4to1_bus #(.DW(DW)) u_bus (
        .sel (sel),
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .out (out_data)
    );

    // Arbitration FSM with registered grant, sel and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            sel      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state         <= BUSY;
                        sel           <= winner;
                        grant         <= '0;
                        grant[winner] <= 1'b1;
                        busy          <= 1'b1;
                        hold_cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (burst_end) begin
                        state    <= IDLE;
                        grant    <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        ptr      <= sel + 2'd1;
                    end else if (xfer) begin
                        hold_cnt <= hold_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter DW, default 8, width of each requester data bus.
REQ-002 Parameter MAX_HOLD, default 4, maximum accepted transfers per grant; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  4  request per requester, bit i = requester i.
REQ-006 last  input  4  final-beat flag per requester, sampled only for the granted requester.
REQ-007 in0, in1, in2, in3  input  DW each  requester data buses.
REQ-008 out_ready  input  1  downstream ready to accept.
REQ-009 out_valid  output  1  output beat valid.
REQ-010 out_data  output  DW  selected requester data.
REQ-011 grant  output  4  one-hot grant, all-zero when idle.
REQ-012 sel  output  2  encoded index of the granted requester.
REQ-013 busy  output  1  high while a grant is held.

Function
REQ-014 Two states: IDLE and BUSY.
REQ-015 IDLE: grant=0, busy=0, out_valid=0; if any req bit is high, the next state is BUSY.
REQ-016 Arbitration is round-robin: search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first requester with req high wins.
REQ-017 Latency is one cycle: request sampled in IDLE, so grant, sel and busy are registered and valid on the following edge.
REQ-018 BUSY: sel holds the winner index, grant[sel]=1, out_valid = req[sel], out_data = in[sel] combinationally through the datapath mux.
REQ-019 A transfer occurs on a cycle with out_valid=1 and out_ready=1; the hold counter increments on each transfer.
REQ-020 The burst ends on the first of the following: a transfer with last[sel]=1; a transfer that brings the hold count to MAX_HOLD; or req[sel]=0, which releases the grant.
REQ-021 At burst end: the next state is IDLE, grant clears, the hold counter clears, and ptr becomes sel+1 (mod 4, so 3 wraps to 0).
REQ-022 Exactly one idle cycle separates consecutive grants, including when the same or another requester is still requesting.
REQ-023 Requests from non-granted requesters are ignored while BUSY, and last on non-granted lines is ignored.
REQ-024 out_ready low stalls the burst indefinitely: no count change and no timeout.
REQ-025 If last[sel]=1 coincides with the MAX_HOLD-th transfer, the burst ends exactly once, with no double pointer advance.
REQ-026 The hold counter is 4 bits and never exceeds MAX_HOLD.
REQ-027 With MAX_HOLD=1, every grant ends after a single transfer.

Reset
REQ-028 rst_n low asynchronously forces: state=IDLE, ptr=0, hold count=0, grant=0, sel=0, busy=0, out_valid=0.
REQ-029 out_data reads in0 during reset, because sel=0.
REQ-030 Reset asserted mid-burst abandons the burst immediately, with no completion beat.
REQ-031 The first arbitration after reset release starts from requester 0.

Structure
REQ-032 The shared package mux4_arb_pkg holds the state type (IDLE, BUSY), NUM_REQ=4 and the SEL_W=2 constant.
REQ-033 A single sub-module, mux4to1_bus (4:1 mux with width DW), implements the datapath; the arbiter drives only its select input.
REQ-034 The arbiter logic is otherwise flat, with no further hierarchy.

Verification
REQ-035 Reset then req=4'b0001, out_ready=1, last beat 2 -> grant=0001 one cycle after req, two transfers, then grant=0000 for one cycle; ptr=1.
REQ-036 req=4'b1111 held, last=4'b1111, out_ready=1 -> grants in order 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
REQ-037 MAX_HOLD=4, req=4'b0100, last=0, out_ready=1 -> exactly 4 transfers, forced release, and requester 2 re-granted after one idle cycle.
REQ-038 Grant to requester 1, out_ready=0 for 10 cycles -> out_valid=1 held, no count change; the burst completes normally after ready returns.
REQ-039 Grant to requester 3, req[3] dropped mid-burst -> grant clears on the next edge and ptr wraps to 0.
REQ-040 rst_n pulsed low mid-burst (asynchronously, between clock edges) -> grant, busy and out_valid go to 0 immediately; after release, req=4'b1000 yields grant=1000 one cycle later.
